data_output_collect: RTL

- Output-side counterpart of the input buffer/setup path. Collects the skewed per-lane results leaving the systolic array (BAND_WIDTH lanes, each delayed one cycle more than the previous lane).
- Deskews them in per-lane FIFOs.
- Serialises them row-major onto a single output-buffer write port (wea/addra/dia style).
- Uses the same banked address layout as the input buffer: MSBs select the lane BRAM, LSBs select the word within it.

---
 rtl/data_output_collect_if.sv | 29 ++
 rtl/data_output_collect.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/data_output_collect_if.sv
// Output-collect bus: SA result lanes in, stall back, single banked write port out.
interface data_output_collect_if #(
  parameter int SRAM_DEPTH = 1024,
  parameter int BAND_WIDTH = 25,
  parameter int DATA_WIDTH = 8
);
  localparam int AW = $clog2(SRAM_DEPTH) + $clog2(BAND_WIDTH);

  logic                                  start_i;
  logic [$clog2(SRAM_DEPTH):0]           BURST_SIZE;
  logic [BAND_WIDTH-1:0]                 sa_valid_i;
  logic [BAND_WIDTH-1:0][DATA_WIDTH-1:0] sa_data_i;
  logic                                  stall_o;
  logic                                  wea_o;
  logic [AW-1:0]                         addra_o;
  logic [DATA_WIDTH-1:0]                 dia_o;
  logic                                  done_o;
  logic                                  overflow_o;

  modport master (
    output start_i, BURST_SIZE, sa_valid_i, sa_data_i,
    input  stall_o, wea_o, addra_o, dia_o, done_o, overflow_o
  );

  modport slave (
    input  start_i, BURST_SIZE, sa_valid_i, sa_data_i,
    output stall_o, wea_o, addra_o, dia_o, done_o, overflow_o
  );
endinterface

// File: rtl/data_output_collect.sv
// Deskews skewed systolic-array result lanes in per-lane FIFOs and serialises them
// row-major onto one banked output-buffer write port ({lane, row} addressing).
module data_output_collect #(
  parameter int SRAM_DEPTH = 1024,
  parameter int BAND_WIDTH = 25,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  data_output_collect_if.slave bus
);
  localparam int RAW = $clog2(SRAM_DEPTH);
  localparam int LW  = $clog2(BAND_WIDTH);
  localparam int RW  = RAW + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                state_q;
  logic [RW-1:0]         burst_q;
  logic [RW-1:0]         row_q;
  logic [LW-1:0]         lane_q;
  logic                  wea_q;
  logic                  done_q;
  logic                  overflow_q;
  logic [RAW+LW-1:0]     addra_q;
  logic [DATA_WIDTH-1:0] dia_q;

  logic [DATA_WIDTH-1:0]         mem_q [BAND_WIDTH][FIFO_DEPTH];
  logic [BAND_WIDTH-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [BAND_WIDTH-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [BAND_WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [BAND_WIDTH-1:0]         push;
  logic [BAND_WIDTH-1:0]         pop;
  logic [BAND_WIDTH-1:0]         near_full;
  logic                          pop_any;
  logic                          drop_any;
  logic                          start_acc;
  logic [DATA_WIDTH-1:0]         head;

  assign start_acc = (state_q == IDLE) && bus.start_i;
  assign head      = mem_q[lane_q][rd_ptr_q[lane_q]];

  // Only the FIFO whose turn it is may be popped, and only while draining.
  always_comb begin
    pop     = '0;
    pop_any = (state_q == DRAIN) && (cnt_q[lane_q] != '0);
    if (pop_any) pop[lane_q] = 1'b1;
  end

  always_comb begin
    push      = '0;
    near_full = '0;
    drop_any  = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    for (int k = 0; k < BAND_WIDTH; k++) begin
      if (bus.sa_valid_i[k]) begin
        if (cnt_q[k] == CW'(FIFO_DEPTH)) drop_any = 1'b1;
        else                             push[k]  = 1'b1;
      end
      // Two spare entries cover the SA reacting to stall one cycle late.
      near_full[k] = cnt_q[k] >= CW'(FIFO_DEPTH - 2);
      wr_ptr_d[k]  = wr_ptr_q[k] + PW'(push[k]);
      rd_ptr_d[k]  = rd_ptr_q[k] + PW'(pop[k]);
      cnt_d[k]     = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < BAND_WIDTH; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= bus.sa_data_i[k];
    end
  end

  // Drain FSM: walks lanes 0..BAND_WIDTH-1 per row, waiting on the current lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      row_q      <= '0;
      lane_q     <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dia_q      <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wea_q  <= 1'b0;
      done_q <= 1'b0;
      if (start_acc)     overflow_q <= drop_any;
      else if (drop_any) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            burst_q <= bus.BURST_SIZE;
            row_q   <= '0;
            lane_q  <= '0;
            state_q <= (bus.BURST_SIZE == '0) ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          if (pop_any) begin
            wea_q   <= 1'b1;
            addra_q <= {lane_q, row_q[RAW-1:0]};
            dia_q   <= head;
            if (lane_q == LW'(BAND_WIDTH - 1)) begin
              lane_q <= '0;
              row_q  <= row_q + RW'(1);
              if (row_q == burst_q - RW'(1)) state_q <= DONE;
            end else begin
              lane_q <= lane_q + LW'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall_o    = |near_full;
  assign bus.wea_o      = wea_q;
  assign bus.addra_o    = addra_q;
  assign bus.dia_o      = dia_q;
  assign bus.done_o     = done_q;
  assign bus.overflow_o = overflow_q;
endmodule
